// File: rtl/jtbubl_snd_comm.sv
// Sound-CPU end of the main/sound command channel: command latch with NMI, reply latch, status flags.
// Optional overrun flags are enabled by defining JTBUBL_SNDCOMM_OVR_EN.
module jtbubl_snd_comm #(
   parameter logic NMI_EN_RST = 1'b0
) (
   input  logic       clk24,
   input  logic       rst,
   input  logic       main_wr,
   input  logic [7:0] main_din,
   input  logic       main_rd,
   input  logic       main_stat_rd,
   output logic [7:0] main_dout,
   input  logic       snd_rd,
   input  logic       snd_wr,
   input  logic       snd_nmi_on,
   input  logic       snd_nmi_off,
   input  logic [7:0] snd_din,
   output logic [7:0] snd_dout,
   input  logic       snd_stat_rd,
   output logic       snd_nmi_n
);
   localparam int DATA_W = 8;

   logic              main_wr_p1, main_rd_p1, main_stat_p1;
   logic              snd_rd_p1, snd_wr_p1, snd_stat_p1;
   logic              nmi_on_p1, nmi_off_p1;

   logic [DATA_W-1:0] cmd_latch, rep_latch;
   logic              cmd_pend, rep_full, nmi_en;
   logic              ovr_cmd, ovr_rep;
   logic [DATA_W-1:0] status;

   logic              cmd_set, cmd_clr, rep_set, rep_clr;
   logic              en_set, en_clr, stat_clr;

   // Previous-sample registers; a strobe already high at reset release counts as one edge
   always_ff @(posedge clk24) begin
      if (rst) begin
         main_wr_p1   <= 1'b0;
         main_rd_p1   <= 1'b0;
         main_stat_p1 <= 1'b0;
         snd_rd_p1    <= 1'b0;
         snd_wr_p1    <= 1'b0;
         snd_stat_p1  <= 1'b0;
         nmi_on_p1    <= 1'b0;
         nmi_off_p1   <= 1'b0;
      end else begin
         main_wr_p1   <= main_wr;
         main_rd_p1   <= main_rd;
         main_stat_p1 <= main_stat_rd;
         snd_rd_p1    <= snd_rd;
         snd_wr_p1    <= snd_wr;
         snd_stat_p1  <= snd_stat_rd;
         nmi_on_p1    <= snd_nmi_on;
         nmi_off_p1   <= snd_nmi_off;
      end
   end

   always_comb begin
      cmd_set  =  main_wr     & ~main_wr_p1;
      cmd_clr  = ~snd_rd      &  snd_rd_p1;
      rep_set  =  snd_wr      & ~snd_wr_p1;
      rep_clr  = ~main_rd     &  main_rd_p1;
      en_set   =  snd_nmi_on  & ~nmi_on_p1;
      en_clr   =  snd_nmi_off & ~nmi_off_p1;
      stat_clr = (~main_stat_rd & main_stat_p1) | (~snd_stat_rd & snd_stat_p1);
   end

   // Command path: a new write always wins over the sound CPU's acknowledge
   always_ff @(posedge clk24) begin
      if (rst) begin
         cmd_latch <= '0;
         cmd_pend  <= 1'b0;
      end else begin
         if (cmd_set) begin
            cmd_latch <= main_din;
            cmd_pend  <= 1'b1;
         end else if (cmd_clr) begin
            cmd_pend  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk24) begin
      if (rst) begin
         rep_latch <= '0;
         rep_full  <= 1'b0;
      end else begin
         if (rep_set) begin
            rep_latch <= snd_din;
            rep_full  <= 1'b1;
         end else if (rep_clr) begin
            rep_full  <= 1'b0;
         end
      end
   end

   // NMI enable: disable has priority when both strobes rise together
   always_ff @(posedge clk24) begin
      if (rst) begin
         nmi_en    <= NMI_EN_RST;
         snd_nmi_n <= 1'b1;
      end else begin
         if (en_clr)
            nmi_en <= 1'b0;
         else if (en_set)
            nmi_en <= 1'b1;
         snd_nmi_n <= ~(cmd_pend & nmi_en);
      end
   end

`ifdef JTBUBL_SNDCOMM_OVR_EN
   always_ff @(posedge clk24) begin
      if (rst) begin
         ovr_cmd <= 1'b0;
         ovr_rep <= 1'b0;
      end else begin
         if (cmd_set && cmd_pend)
            ovr_cmd <= 1'b1;
         else if (stat_clr)
            ovr_cmd <= 1'b0;
         if (rep_set && rep_full)
            ovr_rep <= 1'b1;
         else if (stat_clr)
            ovr_rep <= 1'b0;
      end
   end
`else
   always_comb begin
      ovr_cmd = 1'b0;
      ovr_rep = 1'b0;
   end

   logic unused_stat;
   assign unused_stat = stat_clr;
`endif

   always_comb begin
      status    = {4'b0000, ovr_rep, ovr_cmd, rep_full, cmd_pend};
      snd_dout  = snd_stat_rd  ? status : cmd_latch;
      main_dout = main_stat_rd ? status : rep_latch;
   end

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Directed bench for jtbubl_snd_comm; expected values are hand-computed per scenario.
`timescale 1ns/1ps
module tb_jtbubl_snd_comm;
   logic       clk24 = 1'b0;
   logic       rst = 1'b1;
   logic       main_wr = 1'b0, main_rd = 1'b0, main_stat_rd = 1'b0;
   logic [7:0] main_din = 8'h00;
   logic [7:0] main_dout;
   logic       snd_rd = 1'b0, snd_wr = 1'b0, snd_nmi_on = 1'b0, snd_nmi_off = 1'b0;
   logic       snd_stat_rd = 1'b0;
   logic [7:0] snd_din = 8'h00;
   logic [7:0] snd_dout;
   logic       snd_nmi_n;

   int vecs = 0;
   int errs = 0;

   jtbubl_snd_comm #(.NMI_EN_RST(1'b0)) dut (
      .clk24(clk24), .rst(rst),
      .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
      .main_stat_rd(main_stat_rd), .main_dout(main_dout),
      .snd_rd(snd_rd), .snd_wr(snd_wr), .snd_nmi_on(snd_nmi_on),
      .snd_nmi_off(snd_nmi_off), .snd_din(snd_din), .snd_dout(snd_dout),
      .snd_stat_rd(snd_stat_rd), .snd_nmi_n(snd_nmi_n)
   );

   always #5 clk24 = ~clk24;

   task automatic tick();
      @(posedge clk24);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      vecs++; if (snd_dout !== 8'h00) begin $display("FAIL reset_snd_dout got %h want 00", snd_dout); errs++; end
      vecs++; if (main_dout !== 8'h00) begin $display("FAIL reset_main_dout got %h want 00", main_dout); errs++; end
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL reset_nmi got %b want 1", snd_nmi_n); errs++; end
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== 8'h00) begin $display("FAIL reset_snd_status got %h want 00", snd_dout); errs++; end
      snd_stat_rd = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_cmd_no_nmi();
      main_din = 8'h5A; main_wr = 1'b1;
      tick();
      vecs++; if (snd_dout !== 8'h5A) begin $display("FAIL cmd_latch got %h want 5a", snd_dout); errs++; end
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL cmd_nmi_off_%0d got %b want 1", i, snd_nmi_n); errs++; end
      end
      main_wr = 1'b0;
      tick();
      snd_stat_rd = 1'b1; main_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== 8'h01) begin $display("FAIL cmd_snd_status got %h want 01", snd_dout); errs++; end
      vecs++; if (main_dout !== 8'h01) begin $display("FAIL cmd_main_status got %h want 01", main_dout); errs++; end
      snd_stat_rd = 1'b0; main_stat_rd = 1'b0;
      snd_rd = 1'b1; tick();
      snd_rd = 1'b0; tick();
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== 8'h00) begin $display("FAIL cmd_ack_status got %h want 00", snd_dout); errs++; end
      snd_stat_rd = 1'b0;
      tick();
   endtask

   task automatic test_nmi();
      snd_nmi_on = 1'b1; tick();
      snd_nmi_on = 1'b0; tick();
      main_din = 8'h33; main_wr = 1'b1;
      tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL nmi_cycle1 got %b want 1", snd_nmi_n); errs++; end
      main_wr = 1'b0;
      tick();
      vecs++; if (snd_nmi_n !== 1'b0) begin $display("FAIL nmi_cycle2 got %b want 0", snd_nmi_n); errs++; end
      vecs++; if (snd_dout !== 8'h33) begin $display("FAIL nmi_cmd got %h want 33", snd_dout); errs++; end
      snd_rd = 1'b1;
      repeat (3) tick();
      snd_rd = 1'b0;
      tick();
      vecs++; if (snd_nmi_n !== 1'b0) begin $display("FAIL nmi_ack_k1 got %b want 0", snd_nmi_n); errs++; end
      tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL nmi_ack_k2 got %b want 1", snd_nmi_n); errs++; end
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== 8'h00) begin $display("FAIL nmi_ack_status got %h want 00", snd_dout); errs++; end
      snd_stat_rd = 1'b0;
   endtask

   task automatic test_nmi_toggle();
      main_din = 8'h77; main_wr = 1'b1; tick();
      main_wr = 1'b0; tick();
      vecs++; if (snd_nmi_n !== 1'b0) begin $display("FAIL tog_nmi_on got %b want 0", snd_nmi_n); errs++; end
      snd_nmi_off = 1'b1; tick();
      snd_nmi_off = 1'b0; tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL tog_nmi_disabled got %b want 1", snd_nmi_n); errs++; end
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== 8'h01) begin $display("FAIL tog_pend_kept got %h want 01", snd_dout); errs++; end
      snd_stat_rd = 1'b0;
      snd_nmi_on = 1'b1; tick();
      snd_nmi_on = 1'b0; tick();
      vecs++; if (snd_nmi_n !== 1'b0) begin $display("FAIL tog_nmi_reenabled got %b want 0", snd_nmi_n); errs++; end
      snd_nmi_on = 1'b1; snd_nmi_off = 1'b1; tick();
      snd_nmi_on = 1'b0; snd_nmi_off = 1'b0; tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL tog_off_wins got %b want 1", snd_nmi_n); errs++; end
      snd_nmi_on = 1'b1; tick();
      snd_nmi_on = 1'b0; tick();
      snd_rd = 1'b1; tick();
      snd_rd = 1'b0; tick(); tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL tog_cleared got %b want 1", snd_nmi_n); errs++; end
   endtask

   task automatic test_reply();
      snd_din = 8'hC4; snd_wr = 1'b1; tick();
      snd_wr = 1'b0; snd_din = 8'h00; tick();
      main_stat_rd = 1'b1; #1;
      vecs++; if (main_dout !== 8'h02) begin $display("FAIL rep_status got %h want 02", main_dout); errs++; end
      main_stat_rd = 1'b0; main_rd = 1'b1; #1;
      vecs++; if (main_dout !== 8'hC4) begin $display("FAIL rep_data got %h want c4", main_dout); errs++; end
      tick(); tick();
      main_rd = 1'b0; tick();
      main_stat_rd = 1'b1; snd_stat_rd = 1'b1; #1;
      vecs++; if (main_dout !== 8'h00) begin $display("FAIL rep_cleared got %h want 00", main_dout); errs++; end
      vecs++; if (snd_dout !== 8'h00) begin $display("FAIL rep_snd_status got %h want 00", snd_dout); errs++; end
      main_stat_rd = 1'b0; snd_stat_rd = 1'b0;
      tick();
   endtask

   task automatic test_overrun();
      logic [7:0] exp_st;
`ifdef JTBUBL_SNDCOMM_OVR_EN
      exp_st = 8'h05;
`else
      exp_st = 8'h01;
`endif
      main_din = 8'h01; main_wr = 1'b1; tick();
      main_wr = 1'b0; tick();
      main_din = 8'h02; main_wr = 1'b1; tick();
      main_wr = 1'b0; tick();
      vecs++; if (snd_dout !== 8'h02) begin $display("FAIL ovr_overwrite got %h want 02", snd_dout); errs++; end
      vecs++; if (snd_nmi_n !== 1'b0) begin $display("FAIL ovr_nmi got %b want 0", snd_nmi_n); errs++; end
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== exp_st) begin $display("FAIL ovr_status got %h want %h", snd_dout, exp_st); errs++; end
      tick();
      snd_stat_rd = 1'b0; tick();
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== 8'h01) begin $display("FAIL ovr_status_clr got %h want 01", snd_dout); errs++; end
      snd_stat_rd = 1'b0;
      snd_rd = 1'b1; tick();
      snd_rd = 1'b0; tick(); tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_st;
`ifdef JTBUBL_SNDCOMM_OVR_EN
      exp_st = 8'h05;
`else
      exp_st = 8'h01;
`endif
      main_din = 8'h10; main_wr = 1'b1; tick();
      main_wr = 1'b0; tick();
      snd_rd = 1'b1; tick();
      snd_rd = 1'b0; main_din = 8'hAB; main_wr = 1'b1; tick();
      main_wr = 1'b0;
      vecs++; if (snd_dout !== 8'hAB) begin $display("FAIL b2b_data got %h want ab", snd_dout); errs++; end
      snd_stat_rd = 1'b1; #1;
      vecs++; if (snd_dout !== exp_st) begin $display("FAIL b2b_status got %h want %h", snd_dout, exp_st); errs++; end
      snd_stat_rd = 1'b0;
      tick();
      vecs++; if (snd_nmi_n !== 1'b0) begin $display("FAIL b2b_nmi got %b want 0", snd_nmi_n); errs++; end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL rmid_nmi got %b want 1", snd_nmi_n); errs++; end
      vecs++; if (snd_dout !== 8'h00) begin $display("FAIL rmid_cmd got %h want 00", snd_dout); errs++; end
      main_din = 8'h05; main_wr = 1'b1; tick();
      rst = 1'b0; tick();
      vecs++; if (snd_dout !== 8'h05) begin $display("FAIL rel_fire got %h want 05", snd_dout); errs++; end
      main_din = 8'h06; tick(); tick();
      vecs++; if (snd_dout !== 8'h05) begin $display("FAIL rel_once got %h want 05", snd_dout); errs++; end
      main_wr = 1'b0; tick(); tick();
      vecs++; if (snd_nmi_n !== 1'b1) begin $display("FAIL rel_nmi_en_rst got %b want 1", snd_nmi_n); errs++; end
   endtask

   initial begin
      test_reset();
      test_cmd_no_nmi();
      test_nmi();
      test_nmi_toggle();
      test_reply();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
